// File: rtl/aud_dsp_stream.sv
// aud_dsp_stream: fetches mono samples from sample memory and applies the speed control.
// One sample per LRCK frame is presented to the I2S DAC serializer.
// Runs in the BCLK domain. Define AUD_DSP_LINEAR_INTERP_EN to enable linear interpolation
// in slow mode; without it, slow mode holds each sample for N frames.
module aud_dsp_stream #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_daclrck,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic [2:0]        i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_valid,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_player_en,
  output logic              o_done,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StWait  = 2'd2,
    StPause = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        k_q, k_d;
  logic [2:0]        spd_q, spd_d;
  logic              fast_q, fast_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              lrck_q;
  logic [DATA_W-1:0] s0_q, s0_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic              done_q, done_d;
  // last_q: final sample is on air; the next frame edge ends playback
  logic              last_q, last_d;
  // fetched_q: sample(s) for the current addr are in s0 (and s1)
  logic              fetched_q, fetched_d;
  // pend_q: a read was in flight when pause hit; keep requesting until it lands
  logic              pend_q, pend_d;

  logic              frame_edge;
  logic [3:0]        n_val;
  logic [ADDR_W:0]   step_addr;
  logic              rd_req, rd_done, rd_last;
  logic [DATA_W-1:0] out_sample;

`ifdef AUD_DSP_LINEAR_INTERP_EN
  logic [DATA_W-1:0]        s1_q, s1_d;
  logic                     rd_idx_q, rd_idx_d;
  logic                     interp_on, need_two;
  logic [ADDR_W:0]          addr_p1;
  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W+3:0] prod, quot;
`endif

  assign frame_edge = !lrck_q && i_daclrck;
  assign n_val      = {1'b0, spd_q} + 4'd1;
  // Extra MSB so an advance past the top of the address space cannot wrap.
  assign step_addr  = {1'b0, addr_q} + {{(ADDR_W-3){1'b0}}, (fast_q ? n_val : 4'd1)};
  assign rd_req     = (state_q == StFetch) || ((state_q == StPause) && pend_q);
  assign rd_done    = rd_req && i_rd_valid;

`ifdef AUD_DSP_LINEAR_INTERP_EN
  assign interp_on  = !fast_q && (spd_q != 3'd0);
  assign addr_p1    = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign need_two   = interp_on && (addr_p1 <= {1'b0, end_q});
  assign rd_last    = rd_done && (rd_idx_q || !need_two);
  assign o_rd_addr  = addr_q + {{(ADDR_W-1){1'b0}}, rd_idx_q};
  assign diff       = $signed({s1_q[DATA_W-1], s1_q}) - $signed({s0_q[DATA_W-1], s0_q});
  assign prod       = $signed({{3{diff[DATA_W]}}, diff}) * $signed({{(DATA_W+1){1'b0}}, k_q});
  // Signed division truncates toward zero.
  assign quot       = prod / $signed({{DATA_W{1'b0}}, n_val});
  assign out_sample = interp_on ? (s0_q + quot[DATA_W-1:0]) : s0_q;
`else
  assign rd_last    = rd_done;
  assign o_rd_addr  = addr_q;
  assign out_sample = s0_q;
`endif

  assign o_rd_req    = rd_req;
  assign o_dac_data  = dac_q;
  assign o_player_en = (state_q == StFetch) || (state_q == StWait);
  assign o_done      = done_q;
  assign o_state     = state_q;

  // Next-state: command decode (stop > pause > start), fetch and frame-edge advance.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    k_d       = k_q;
    spd_d     = spd_q;
    fast_d    = fast_q;
    end_d     = end_q;
    s0_d      = s0_q;
    dac_d     = dac_q;
    done_d    = 1'b0;
    last_d    = last_q;
    fetched_d = fetched_q;
    pend_d    = pend_q;
`ifdef AUD_DSP_LINEAR_INTERP_EN
    s1_d      = s1_q;
    rd_idx_d  = rd_idx_q;
`endif

    if (frame_edge || i_start) begin
      spd_d  = i_speed;
      fast_d = i_fast;
      end_d  = i_end_addr;
    end

    if (rd_done) begin
`ifdef AUD_DSP_LINEAR_INTERP_EN
      if (!rd_idx_q) s0_d = i_rd_data;
      // Single read (or addr+1 past the end) leaves s1 equal to s0.
      if (rd_idx_q || !need_two) s1_d = i_rd_data;
      rd_idx_d = !rd_last;
`else
      s0_d = i_rd_data;
`endif
      if (rd_last) fetched_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_start && !i_pause) begin
          state_d   = StFetch;
          addr_d    = '0;
          k_d       = '0;
          fetched_d = 1'b0;
          last_d    = 1'b0;
        end
      end
      StFetch: begin
        // A frame edge here is an underrun: dac_q simply holds.
        if (i_pause) begin
          state_d = StPause;
          pend_d  = !rd_done;
        end else if (rd_last) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (i_pause) begin
          state_d = StPause;
          pend_d  = 1'b0;
        end else if (frame_edge) begin
          if (last_q) begin
            done_d    = 1'b1;
            state_d   = StIdle;
            addr_d    = '0;
            k_d       = '0;
            dac_d     = '0;
            last_d    = 1'b0;
            fetched_d = 1'b0;
          end else begin
            dac_d = out_sample;
            if (fast_q || (k_q == spd_q)) begin
              k_d = '0;
              if (step_addr > {1'b0, end_q}) begin
                last_d = 1'b1;
              end else begin
                addr_d    = step_addr[ADDR_W-1:0];
                state_d   = StFetch;
                fetched_d = 1'b0;
              end
            end else begin
              k_d = k_q + 3'd1;
            end
          end
        end
      end
      StPause: begin
        if (rd_done) pend_d = 1'b0;
        if (i_start && !i_pause) begin
          state_d = (fetched_q || rd_last) ? StWait : StFetch;
          pend_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (i_stop) begin
      state_d   = StIdle;
      addr_d    = '0;
      k_d       = '0;
      dac_d     = '0;
      done_d    = 1'b0;
      last_d    = 1'b0;
      fetched_d = 1'b0;
      pend_d    = 1'b0;
`ifdef AUD_DSP_LINEAR_INTERP_EN
      rd_idx_d  = 1'b0;
`endif
    end
  end

  // State registers with synchronous active-low reset; lrck_q always tracks the pin.
  always_ff @(posedge i_clk) begin
    lrck_q <= i_daclrck;
    if (!i_rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      k_q       <= '0;
      spd_q     <= '0;
      fast_q    <= 1'b0;
      end_q     <= '0;
      s0_q      <= '0;
      dac_q     <= '0;
      done_q    <= 1'b0;
      last_q    <= 1'b0;
      fetched_q <= 1'b0;
      pend_q    <= 1'b0;
`ifdef AUD_DSP_LINEAR_INTERP_EN
      s1_q      <= '0;
      rd_idx_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      k_q       <= k_d;
      spd_q     <= spd_d;
      fast_q    <= fast_d;
      end_q     <= end_d;
      s0_q      <= s0_d;
      dac_q     <= dac_d;
      done_q    <= done_d;
      last_q    <= last_d;
      fetched_q <= fetched_d;
      pend_q    <= pend_d;
`ifdef AUD_DSP_LINEAR_INTERP_EN
      s1_q      <= s1_d;
      rd_idx_q  <= rd_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_aud_dsp_stream.sv
// Bench for aud_dsp_stream: scoreboard of expected per-frame DAC samples, memory model
// with programmable latency, LRCK of 32 BCLK per frame.
module tb_aud_dsp_stream;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;
  localparam int FRAME = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              daclrck = 1'b0;
  logic              start = 1'b0, pause = 1'b0, stop = 1'b0, fast = 1'b0;
  logic [2:0]        speed = 3'd0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0] dac_data;
  logic              player_en, done;
  logic [1:0]        state;

  logic [DATA_W-1:0] mem [0:15];
  int lat = 2;
  bit mem_hold = 1'b0;
  int checks = 0, errors = 0, done_cnt = 0, lr_cnt = 0;
  int exp_q[$];

  aud_dsp_stream #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_daclrck(daclrck),
    .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_fast(fast), .i_speed(speed), .i_end_addr(end_addr),
    .o_rd_req(rd_req), .o_rd_addr(rd_addr),
    .i_rd_valid(rd_valid), .i_rd_data(rd_data),
    .o_dac_data(dac_data), .o_player_en(player_en),
    .o_done(done), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // LRCK: 16 cycles low, 16 high, driven on the falling BCLK edge.
  initial forever begin
    @(negedge clk);
    lr_cnt  = (lr_cnt + 1) % FRAME;
    daclrck = (lr_cnt >= FRAME / 2);
  end

  // Sample memory: answers a held request after 'lat' cycles with a one-cycle valid.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!mem_hold) begin
        rd_valid = 1'b0;
        if (rd_req) begin
          cnt++;
          if (cnt >= lat) begin
            rd_valid = 1'b1;
            rd_data  = mem[rd_addr[3:0]];
            cnt      = 0;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: each frame edge with the player enabled consumes one expected sample.
  initial forever begin
    int e;
    @(posedge daclrck);
    @(posedge clk);
    @(negedge clk);
    if (player_en) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_out_qdepth", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("dac", $signed(dac_data), e);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic pulse_cmd(input bit s, input bit p, input bit t);
    @(negedge clk);
    start = s; pause = p; stop = t;
    @(negedge clk);
    start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  task automatic sync_frame();
    @(posedge daclrck);
    repeat (2) @(posedge clk);
  endtask

  task automatic play(input bit f, input logic [2:0] sp, input logic [ADDR_W-1:0] e);
    fast = f; speed = sp; end_addr = e; done_cnt = 0;
    sync_frame();
    pulse_cmd(1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_to_end(input string tag);
    int n;
    n = 0;
    while (!(done_cnt > 0 && state == 2'd0) && n < 1500) begin
      @(posedge clk); #2; n++;
    end
    repeat (FRAME + 4) @(posedge clk);
    #2;
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    check_eq({tag, "_state"}, state, 0);
    check_eq({tag, "_dac_zero"}, $signed(dac_data), 0);
    check_eq({tag, "_q_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_dac(input logic [DATA_W-1:0] v, input string tag);
    int n;
    n = 0;
    while (dac_data !== v && n < 2000) begin
      @(posedge clk); #2; n++;
    end
    check_eq(tag, $signed(dac_data), $signed(v));
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) mem[i] = DATA_W'(i * 100);
  endtask

  initial begin
    int n;
    fill_ramp();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", state, 0);
    check_eq("rst_rd_req", rd_req, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_dac", dac_data, 0);
    check_eq("rst_player_en", player_en, 0);
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;

    // Fast, N=1, end 7: ramp 0..700.
    for (int i = 0; i < 8; i++) exp_q.push_back(i * 100);
    play(1'b1, 3'd0, 7);
    run_to_end("fast_n1");

    // Fast, N=3, end 9.
    push4(0, 300, 600, 900);
    play(1'b1, 3'd2, 9);
    run_to_end("fast_n3");

    // Slow, N=4, two samples.
    mem[0] = 16'd0; mem[1] = 16'd400;
`ifdef AUD_DSP_LINEAR_INTERP_EN
    push4(0, 100, 200, 300);
`else
    push4(0, 0, 0, 0);
`endif
    push4(400, 400, 400, 400);
    play(1'b0, 3'd3, 1);
    run_to_end("slow_n4");

    // Slow, N=2, negative second sample.
    mem[1] = 16'hFFF9;
`ifdef AUD_DSP_LINEAR_INTERP_EN
    push4(0, -3, -7, -7);
`else
    push4(0, 0, -7, -7);
`endif
    play(1'b0, 3'd1, 1);
    run_to_end("slow_neg");

    // Pause in WAIT after 200, hold 5 frames, resume with 300.
    fill_ramp();
    for (int i = 0; i < 8; i++) exp_q.push_back(i * 100);
    play(1'b1, 3'd0, 7);
    wait_dac(16'd200, "pause_reach_200");
    repeat (6) @(posedge clk);
    pulse_cmd(1'b0, 1'b1, 1'b0);
    check_eq("pause_state", state, 3);
    check_eq("pause_en", player_en, 0);
    repeat (5 * FRAME) @(posedge clk);
    #2;
    check_eq("pause_dac_frozen", $signed(dac_data), 200);
    check_eq("pause_addr_frozen", rd_addr, 3);
    check_eq("pause_state_held", state, 3);
    sync_frame();
    pulse_cmd(1'b1, 1'b0, 1'b0);
    check_eq("resume_state", state, 2);
    run_to_end("pause_resume");

    // Underrun: fetch of addr 2 spans a frame edge, 100 repeats once.
    push4(0, 100, 100, 200);
    exp_q.push_back(300);
    play(1'b1, 3'd0, 3);
    wait_dac(16'd100, "underrun_reach_100");
    lat = 40;
    n = 0;
    while (!rd_valid && n < 200) begin
      @(posedge clk); #2; n++;
    end
    check_eq("underrun_valid_seen", rd_valid, 1);
    lat = 2;
    run_to_end("underrun");

    // Stop + pause + start together in FETCH; a late valid must be ignored.
    mem_hold = 1'b1;
    fast = 1'b1; speed = 3'd0; end_addr = 7;
    sync_frame();
    pulse_cmd(1'b1, 1'b0, 1'b0);
    check_eq("stop_pre_state", state, 1);
    check_eq("stop_pre_req", rd_req, 1);
    pulse_cmd(1'b1, 1'b1, 1'b1);
    check_eq("stop_state", state, 0);
    check_eq("stop_req", rd_req, 0);
    check_eq("stop_addr", rd_addr, 0);
    check_eq("stop_en", player_en, 0);
    rd_data  = 16'h1234;
    rd_valid = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    @(negedge clk);
    check_eq("late_valid_dac", $signed(dac_data), 0);
    check_eq("late_valid_state", state, 0);
    mem_hold = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aud_dsp_stream.md
Name: aud_dsp_stream

Overview:
- Upstream playback stage feeding the I2S DAC serializer. Fetches 16-bit mono samples from external sample memory over a req/valid read port.
- Applies speed control: fast = skip samples; slow = repeat or interpolate samples.
- Presents one new sample per LRCK frame on o_dac_data, with an enable that gates the serializer.
- Runs in the BCLK domain alongside the serializer.

Parameters:
ADDR_W, 20, sample memory address width
DATA_W, 16, sample width (signed two's complement)

Ports:
i_clk  in  1  BCLK-domain clock
i_rst_n  in  1  reset; synchronous, active-low
i_daclrck  in  1  DAC LR clock, sampled on i_clk
i_start  in  1  one-cycle pulse: play / resume
i_pause  in  1  one-cycle pulse: pause
i_stop  in  1  one-cycle pulse: stop, rewind to address 0
i_fast  in  1  1 = fast mode, 0 = slow mode
i_speed  in  3  speed factor N = i_speed+1 (1..8)
i_end_addr  in  ADDR_W  last valid sample address
o_rd_req  out  1  read request, held until i_rd_valid
o_rd_addr  out  ADDR_W  read address, stable while o_rd_req=1
i_rd_valid  in  1  read data valid, one-cycle pulse
i_rd_data  in  DATA_W  read data
o_dac_data  out  DATA_W  sample to serializer
o_player_en  out  1  serializer enable
o_done  out  1  one-cycle pulse at end of playback
o_state  out  2  0 IDLE, 1 FETCH, 2 WAIT, 3 PAUSE

Behaviour:
- Reset (i_rst_n=0 at a rising edge of i_clk):
  - state IDLE; addr 0; frame count k 0
  - all outputs 0; lrck_q captures i_daclrck
- Frame edge: lrck_q==0 && i_daclrck==1. lrck_q is a register of i_daclrck.
- N, i_fast and i_end_addr are latched into internal registers on every frame edge and on start. Mid-play changes take effect at the next frame boundary.
- Command priority within one cycle: stop > pause > start.
- Stop, from any state:
  - next cycle: IDLE, addr 0, k 0, o_dac_data 0, o_player_en 0, o_rd_req 0
  - an outstanding read is abandoned; a late i_rd_valid is ignored
- Start:
  - IDLE -> FETCH with addr 0.
  - PAUSE -> FETCH at the held addr/k if the current sample is not yet fetched; otherwise -> WAIT.
  - Ignored in FETCH/WAIT.
- Pause:
  - FETCH/WAIT -> PAUSE. addr, k and o_dac_data are frozen; o_player_en 0.
  - A read in flight completes and is stored.
- FETCH:
  - o_rd_req=1, o_rd_addr=addr. The request drops the cycle after i_rd_valid.
  - i_rd_data is stored into s0; then -> WAIT.
- WAIT: at a frame edge:
  - o_dac_data is loaded with the output sample; o_player_en=1 in FETCH and WAIT.
  - Fast mode: addr += N; -> FETCH.
  - Slow mode: if k==N-1, then k=0, addr += 1, -> FETCH; else k += 1, stay WAIT (no fetch).
  - N=1 behaves identically in both modes.
- Output sample without interpolation: s0.
- End of playback, checked at frame-edge advance:
  - Condition: new addr > end addr (compare at ADDR_W+1 bits; no wrap).
  - Response: o_done=1 for one cycle; -> IDLE; addr 0; o_dac_data 0 on the following cycle.
  - The final sample is still output for its full frame(s).
- Underrun: a frame edge while in FETCH keeps the previous o_dac_data. The address/k advance is deferred: it happens at the first frame edge after the fetch completes. Nothing is skipped.
- Sample memory is read-only; at most one request is outstanding.

Optional Feature:
- Macro: AUD_DSP_LINEAR_INTERP_EN.
- Defined:
  - In slow mode with N>1, FETCH issues two sequential reads, addr then addr+1, into s0 and s1.
  - If addr+1 > end addr, then s1 = s0.
  - Output = s0 + ((s1 - s0) * k) / N. The difference is 17-bit signed and the product 20-bit signed; the division is signed and truncates toward zero. The result fits DATA_W.
  - Fast mode and N=1 use a single read, as without the macro.
- Not defined: zero-order hold; output s0 for all N frames; s1 logic is absent.

Test Plan:
- Reset, then start with memory[i]=i*100, fast, i_speed=0, end=7, at ~32 BCLK per LRCK: o_dac_data = 0,100,...,700 on successive frames; o_done pulses once after the 700 frame; o_dac_data=0; o_state=0.
- Fast, i_speed=2 (N=3), end=9: output 0,300,600,900; then o_done.
- Slow, i_speed=3 (N=4), mem[0]=0, mem[1]=400, end=1:
  - Without the macro: 0,0,0,0,400,400,400,400.
  - With AUD_DSP_LINEAR_INTERP_EN: 0,100,200,300,400,400,400,400.
  - Negative case mem[1]=-7, N=2: with the macro, 0,-3 (truncation toward zero).
- Pause in WAIT after the sample 200 is output: o_player_en=0, addr/o_dac_data frozen over 5 frames. Start: resumes with 300 next.
- Stop, pause and start asserted in the same cycle while in FETCH: next cycle IDLE, o_rd_req=0, addr 0. A late i_rd_valid does not change o_dac_data.
- i_rd_valid delayed past a frame edge: the previous sample repeats for one frame; the following frame outputs the fetched sample; no address is skipped.
